// File: rtl/ntt_intt_pe_ctrl.sv
// ntt_intt_pe_ctrl
// ----------------
// Sequencer for a single radix-2 butterfly processing element running a
// length-2**LOGN NTT or INTT. Each butterfly takes two cycles: ph=0 produces
// the "add" output (written back to the a address), ph=1 produces the "sub"
// output (written back to the b address). Reads and writes use opposite
// ping-pong banks, and the banks swap each stage, so no location is read and
// written in the same stage.
//
// Handshake: start is a request that is accepted only in IDLE, on the clock
// edge where it is sampled high. In any other state start is ignored. There
// is no back-pressure: once accepted, a run always takes LOGN*2**LOGN cycles
// and then pulses done for exactly one cycle.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   start           request one full transform (IDLE only)
//   inv_mode        0 = forward NTT, 1 = INTT; latched on accepted start
//   busy            high while the transform is running
//   done            one-cycle completion pulse
//   rd_addr_a/b     coefficient read addresses for PE operands a and b
//   tf_addr         twiddle ROM address for PE tf
//   pe_sub, pe_inv  PE operation selects
//   wr_en, wr_addr  PE result write strobe and address
//   rd_bank/wr_bank ping-pong bank selects (wr_bank is always ~rd_bank)
//   result_bank     bank holding the finished transform
//   state_dbg       current FSM state, for observation only
//
// All outputs are decoded from registers; no input reaches an output
// combinationally.

module ntt_intt_pe_ctrl #(
  parameter int LOGN = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            inv_mode,
  output logic            busy,
  output logic            done,
  output logic [LOGN-1:0] rd_addr_a,
  output logic [LOGN-1:0] rd_addr_b,
  output logic [LOGN-2:0] tf_addr,
  output logic            pe_sub,
  output logic            pe_inv,
  output logic            wr_en,
  output logic [LOGN-1:0] wr_addr,
  output logic            rd_bank,
  output logic            wr_bank,
  output logic            result_bank,
  output logic [1:0]      state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // k counts butterflies within a stage (NPTS/2 of them); s counts stages.
  localparam logic [LOGN-2:0] K_LAST = '1;
  localparam logic [LOGN-1:0] S_LAST = LOGN'(LOGN - 1);
  localparam logic [LOGN-1:0] ONE    = LOGN'(1);

  state_t          state_q, state_d;
  logic [LOGN-1:0] s_q, s_d;
  logic [LOGN-2:0] k_q, k_d;
  logic            ph_q, ph_d;
  logic            inv_q, inv_d;
  logic            rb_q, rb_d;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      s_q     <= '0;
      k_q     <= '0;
      ph_q    <= 1'b0;
      inv_q   <= 1'b0;
      rb_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      k_q     <= k_d;
      ph_q    <= ph_d;
      inv_q   <= inv_d;
      rb_q    <= rb_d;
    end
  end

  // Next-state and counter advance
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    k_d     = k_q;
    ph_d    = ph_q;
    inv_d   = inv_q;
    rb_d    = rb_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          s_d     = '0;
          k_d     = '0;
          ph_d    = 1'b0;
          inv_d   = inv_mode;
        end
      end
      RUN: begin
        ph_d = ~ph_q;
        if (ph_q) begin
          if (k_q == K_LAST) begin
            k_d = '0;
            if (s_q == S_LAST) begin
              // Last butterfly of the last stage: the result sits in the
              // bank this stage is writing.
              state_d = DONE;
              s_d     = '0;
              rb_d    = ~s_q[0];
            end else begin
              s_d = s_q + ONE;
            end
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Address generation. With half = 2**s, the butterfly index k splits into
  // a group (upper bits) and a position inside the group (low s bits).
  // grp*2*half is simply k with its low s bits cleared, shifted left by one.
  logic            run;
  logic [LOGN-1:0] k_ext;
  logic [LOGN-1:0] half;
  logic [LOGN-1:0] mask;
  logic [LOGN-1:0] pos;
  logic [LOGN-1:0] addr_a;
  logic [LOGN-1:0] addr_b;
  logic [LOGN-2:0] tf;

  always_comb begin
    run    = (state_q == RUN);
    k_ext  = {1'b0, k_q};
    half   = ONE << s_q;
    mask   = half - ONE;
    pos    = k_ext & mask;
    addr_a = ((k_ext & ~mask) << 1) | pos;
    addr_b = addr_a + half;
    // pos < half <= NPTS/2, so it fits the twiddle address width.
    tf     = pos[LOGN-2:0] << (S_LAST - s_q);
  end

  // Output decode
  always_comb begin
    busy        = run;
    done        = (state_q == DONE);
    rd_addr_a   = run ? addr_a : '0;
    rd_addr_b   = run ? addr_b : '0;
    tf_addr     = run ? tf : '0;
    pe_sub      = run & ph_q;
    pe_inv      = inv_q;
    wr_en       = run;
    wr_addr     = run ? (ph_q ? addr_b : addr_a) : '0;
    rd_bank     = run & s_q[0];
    wr_bank     = ~rd_bank;
    result_bank = rb_q;
    state_dbg   = state_q;
  end

endmodule
